// File: rtl/ahb_gpio_pkg.sv
// Shared encodings for the AHB-Lite GPIO controller: bus transfer types,
// register word offsets and the latched data-phase record.
package ahb_gpio_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int unsigned OFF_W = 4;

  localparam logic [OFF_W-1:0] GPIO_IN    = 4'h0;
  localparam logic [OFF_W-1:0] GPIO_OUT   = 4'h1;
  localparam logic [OFF_W-1:0] GPIO_DIR   = 4'h2;
  localparam logic [OFF_W-1:0] GPIO_SET   = 4'h3;
  localparam logic [OFF_W-1:0] GPIO_CLR   = 4'h4;
  localparam logic [OFF_W-1:0] GPIO_TGL   = 4'h5;
  localparam logic [OFF_W-1:0] GPIO_IE    = 4'h6;
  localparam logic [OFF_W-1:0] GPIO_ITYPE = 4'h7;
  localparam logic [OFF_W-1:0] GPIO_ISTAT = 4'h8;

  typedef struct packed {
    logic             valid;
    logic             write;
    logic [OFF_W-1:0] off;
  } dphase_t;

  // NONSEQ and SEQ both carry htrans[1]; IDLE and BUSY never start a transfer.
  function automatic logic ahb_access(input logic       hsel,
                                      input logic       hready,
                                      input logic [1:0] htrans);
    return hsel & hready & htrans[1];
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs; every stage resets to 0.
module gpio_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_chain [STAGES];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < int'(STAGES); i++) r_chain[i] <= '0;
    end else begin
      r_chain[0] <= i_async;
      for (int i = 1; i < int'(STAGES); i++) r_chain[i] <= r_chain[i-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/ahb_gpio_mc.sv
// AHB-Lite GPIO controller: per-pin direction, atomic set/clear/toggle,
// synchronised inputs and edge interrupts folded into one registered line.
module ahb_gpio_mc
  import ahb_gpio_pkg::*;
#(
  parameter int unsigned AWIDTH      = 32,
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned NGPIO       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel_i,
  input  logic              hwrite_i,
  input  logic              hready_i,
  input  logic [2:0]        hsize_i,
  input  logic [2:0]        hburst_i,
  input  logic [1:0]        htrans_i,
  input  logic [AWIDTH-1:0] haddr_i,
  input  logic [DWIDTH-1:0] hwdata_i,
  output logic              hreadyout_o,
  output logic              hresp_o,
  output logic [DWIDTH-1:0] hrdata_o,
  input  logic [NGPIO-1:0]  gpio_i,
  output logic [NGPIO-1:0]  gpio_o,
  output logic [NGPIO-1:0]  gpio_oe_o,
  output logic              irq_o
);

  dphase_t          r_dp;
  logic [NGPIO-1:0] r_out;
  logic [NGPIO-1:0] r_dir;
  logic [NGPIO-1:0] r_ie;
  logic [NGPIO-1:0] r_itype;
  logic [NGPIO-1:0] r_istat;
  logic [NGPIO-1:0] r_in_d;
  logic             r_irq;

  logic             w_access;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [NGPIO-1:0] w_wdata;
  logic [NGPIO-1:0] w_in;
  logic [NGPIO-1:0] w_edge;
  logic [NGPIO-1:0] w_w1c;
  logic [NGPIO-1:0] w_rdata;
  logic             w_unused_ok;

  // Size, burst and address bits outside [5:2] carry no meaning here.
  assign w_unused_ok = ^{hsize_i, hburst_i, htrans_i[0], haddr_i, hwdata_i};

  assign w_access = ahb_access(hsel_i, hready_i, htrans_i);
  assign w_wr_en  = r_dp.valid & r_dp.write;
  assign w_rd_en  = r_dp.valid & ~r_dp.write;
  assign w_wdata  = hwdata_i[NGPIO-1:0];

  // Address-phase capture; a non-access cycle leaves no pending data phase.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_dp <= '0;
    end else if (w_access) begin
      r_dp.valid <= 1'b1;
      r_dp.write <= hwrite_i;
      r_dp.off   <= haddr_i[5:2];
    end else begin
      r_dp <= '0;
    end
  end

  gpio_sync #(
    .WIDTH  (NGPIO),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .hclk    (hclk),
    .hresetn (hresetn),
    .i_async (gpio_i),
    .o_sync  (w_in)
  );

  assign w_edge = (r_itype & r_in_d & ~w_in) | (~r_itype & w_in & ~r_in_d);
  assign w_w1c  = (w_wr_en && (r_dp.off == GPIO_ISTAT)) ? w_wdata : '0;

  // Register file; SET/CLR/TGL act on OUT as read-modify-write.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_out   <= '0;
      r_dir   <= '0;
      r_ie    <= '0;
      r_itype <= '0;
    end else if (w_wr_en) begin
      case (r_dp.off)
        GPIO_OUT:   r_out   <= w_wdata;
        GPIO_DIR:   r_dir   <= w_wdata;
        GPIO_SET:   r_out   <= r_out | w_wdata;
        GPIO_CLR:   r_out   <= r_out & ~w_wdata;
        GPIO_TGL:   r_out   <= r_out ^ w_wdata;
        GPIO_IE:    r_ie    <= w_wdata;
        GPIO_ITYPE: r_itype <= w_wdata;
        default:    ;
      endcase
    end
  end

  // A fresh edge outranks a simultaneous write-1-to-clear on the same pin.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_in_d  <= '0;
      r_istat <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_in_d  <= w_in;
      r_istat <= (r_istat & ~w_w1c) | w_edge;
      r_irq   <= |(r_istat & r_ie);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd_en) begin
      case (r_dp.off)
        GPIO_IN:    w_rdata = w_in;
        GPIO_OUT:   w_rdata = r_out;
        GPIO_DIR:   w_rdata = r_dir;
        GPIO_IE:    w_rdata = r_ie;
        GPIO_ITYPE: w_rdata = r_itype;
        GPIO_ISTAT: w_rdata = r_istat;
        default:    w_rdata = '0;
      endcase
    end
  end

  assign hrdata_o    = DWIDTH'(w_rdata);
  assign hreadyout_o = 1'b1;
  assign hresp_o     = 1'b0;
  assign gpio_o      = r_out;
  assign gpio_oe_o   = r_dir;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_ahb_gpio_mc.sv
// Directed bench for ahb_gpio_mc: vector table for register behaviour plus
// hand-timed sequences for interrupt latency, W1C collision, pipelining, reset.
module tb_ahb_gpio_mc;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NG = 8;
  localparam int unsigned NV = 18;

  logic          hclk;
  logic          hresetn;
  logic          hsel_i;
  logic          hwrite_i;
  logic          hready_i;
  logic [2:0]    hsize_i;
  logic [2:0]    hburst_i;
  logic [1:0]    htrans_i;
  logic [AW-1:0] haddr_i;
  logic [DW-1:0] hwdata_i;
  logic          hreadyout_o;
  logic          hresp_o;
  logic [DW-1:0] hrdata_o;
  logic [NG-1:0] gpio_i;
  logic [NG-1:0] gpio_o;
  logic [NG-1:0] gpio_oe_o;
  logic          irq_o;

  int n_assert = 0;
  int n_fail   = 0;

  ahb_gpio_mc #(
    .AWIDTH(AW), .DWIDTH(DW), .NGPIO(NG), .SYNC_STAGES(2)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel_i(hsel_i), .hwrite_i(hwrite_i),
    .hready_i(hready_i), .hsize_i(hsize_i), .hburst_i(hburst_i),
    .htrans_i(htrans_i), .haddr_i(haddr_i), .hwdata_i(hwdata_i),
    .hreadyout_o(hreadyout_o), .hresp_o(hresp_o), .hrdata_o(hrdata_o),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o), .irq_o(irq_o)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [7:0]  exp_gpio;
    logic [7:0]  exp_oe;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    hsel_i   = 1'b0;
    htrans_i = 2'b00;
    hwrite_i = 1'b0;
    haddr_i  = '0;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a);
    hsel_i   = 1'b1;
    htrans_i = 2'b10;
    hwrite_i = wr;
    haddr_i  = a;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge hclk);
      #1;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr_phase(1'b1, a);
    step(1);
    bus_idle();
    hwdata_i = d;
    step(1);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] rd);
    addr_phase(1'b0, a);
    step(1);
    bus_idle();
    @(negedge hclk);
    rd = hrdata_o;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    vecs[0]  = '{1'b1, 32'h08, 32'h0000_00FF, 32'h0, 8'h00, 8'hFF};
    vecs[1]  = '{1'b1, 32'h04, 32'h0000_00A5, 32'h0, 8'hA5, 8'hFF};
    vecs[2]  = '{1'b1, 32'h0C, 32'h0000_0002, 32'h0, 8'hA7, 8'hFF};
    vecs[3]  = '{1'b1, 32'h10, 32'h0000_0001, 32'h0, 8'hA6, 8'hFF};
    vecs[4]  = '{1'b1, 32'h14, 32'h0000_00F0, 32'h0, 8'h56, 8'hFF};
    vecs[5]  = '{1'b0, 32'h04, 32'h0, 32'h0000_0056, 8'h56, 8'hFF};
    vecs[6]  = '{1'b0, 32'h08, 32'h0, 32'h0000_00FF, 8'h56, 8'hFF};
    vecs[7]  = '{1'b0, 32'h0C, 32'h0, 32'h0000_0000, 8'h56, 8'hFF};
    vecs[8]  = '{1'b0, 32'h10, 32'h0, 32'h0000_0000, 8'h56, 8'hFF};
    vecs[9]  = '{1'b0, 32'h14, 32'h0, 32'h0000_0000, 8'h56, 8'hFF};
    vecs[10] = '{1'b0, 32'h00, 32'h0, 32'h0000_0000, 8'h56, 8'hFF};
    vecs[11] = '{1'b1, 32'h04, 32'hABCD_EF69, 32'h0, 8'h69, 8'hFF};
    vecs[12] = '{1'b0, 32'h04, 32'h0, 32'h0000_0069, 8'h69, 8'hFF};
    vecs[13] = '{1'b0, 32'h24, 32'h0, 32'h0000_0000, 8'h69, 8'hFF};
    vecs[14] = '{1'b1, 32'h18, 32'h0000_0008, 32'h0, 8'h69, 8'hFF};
    vecs[15] = '{1'b0, 32'h18, 32'h0, 32'h0000_0008, 8'h69, 8'hFF};
    vecs[16] = '{1'b1, 32'h1C, 32'h0000_0020, 32'h0, 8'h69, 8'hFF};
    vecs[17] = '{1'b0, 32'h1C, 32'h0, 32'h0000_0020, 8'h69, 8'hFF};

    hresetn  = 1'b0;
    hready_i = 1'b1;
    hsize_i  = 3'b010;
    hburst_i = 3'b000;
    hwdata_i = '0;
    gpio_i   = '0;
    bus_idle();
    step(3);
    hresetn = 1'b1;
    step(2);

    // Reset state.
    chk("rst_gpio_o", 32'(gpio_o), 32'h0);
    chk("rst_gpio_oe", 32'(gpio_oe_o), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk("rst_hreadyout", 32'(hreadyout_o), 32'h1);
    chk("rst_hresp", 32'(hresp_o), 32'h0);
    chk("rst_hrdata_idle", hrdata_o, 32'h0);
    for (int off = 0; off <= 8; off++) begin
      do_read(32'(off * 4), rd);
      chk($sformatf("rst_read_off%0d", off), rd, 32'h0);
    end

    // Register table.
    for (int i = 0; i < int'(NV); i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        do_read(vecs[i].addr, rd);
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      end
      chk($sformatf("vec%0d_gpio_o", i), 32'(gpio_o), 32'(vecs[i].exp_gpio));
      chk($sformatf("vec%0d_gpio_oe", i), 32'(gpio_oe_o), 32'(vecs[i].exp_oe));
    end

    // Rising edge on pin 5 is ignored because ITYPE[5] selects falling.
    gpio_i = 8'h20;
    step(5);
    do_read(32'h20, rd);
    chk("itype_rise_ignored", rd, 32'h0);
    do_read(32'h00, rd);
    chk("in_pin5", rd, 32'h20);

    // Rising edge on pin 3: interrupt latency.
    gpio_i = 8'h28;
    step(1);
    chk("irq_lat_c1", 32'(irq_o), 32'h0);
    step(1);
    chk("irq_lat_c2", 32'(irq_o), 32'h0);
    step(1);
    chk("irq_lat_c3", 32'(irq_o), 32'h0);
    step(1);
    chk("irq_lat_c4", 32'(irq_o), 32'h1);
    do_read(32'h20, rd);
    chk("istat_pin3", rd, 32'h08);
    do_read(32'h00, rd);
    chk("in_pin3_5", rd, 32'h28);
    do_write(32'h20, 32'h08);
    chk("irq_after_w1c_edge", 32'(irq_o), 32'h1);
    step(1);
    chk("irq_cleared", 32'(irq_o), 32'h0);
    do_read(32'h20, rd);
    chk("istat_cleared", rd, 32'h0);

    // Falling edge on pin 5 lands in the same cycle as its W1C: set wins.
    gpio_i = 8'h08;
    step(1);
    addr_phase(1'b1, 32'h20);
    step(1);
    bus_idle();
    hwdata_i = 32'h20;
    step(1);
    do_read(32'h20, rd);
    chk("w1c_collision", rd, 32'h20);
    chk("irq_masked_pin5", 32'(irq_o), 32'h0);
    do_write(32'h20, 32'h20);
    do_read(32'h20, rd);
    chk("w1c_no_collision", rd, 32'h0);

    // Pipelined write then read of OUT with no idle cycle.
    addr_phase(1'b1, 32'h04);
    step(1);
    addr_phase(1'b0, 32'h04);
    hwdata_i = 32'h3C;
    @(negedge hclk);
    chk("b2b_hrdata_wr_phase", hrdata_o, 32'h0);
    chk("b2b_hreadyout_1", 32'(hreadyout_o), 32'h1);
    step(1);
    bus_idle();
    @(negedge hclk);
    chk("b2b_read_out", hrdata_o, 32'h3C);
    chk("b2b_hreadyout_2", 32'(hreadyout_o), 32'h1);
    chk("b2b_gpio_o", 32'(gpio_o), 32'h3C);
    step(1);
    do_read(32'h24, rd);
    chk("unmapped_0x24", rd, 32'h0);

    // Reset asserted in the data phase of a write to OUT.
    gpio_i = '0;
    step(3);
    addr_phase(1'b1, 32'h04);
    step(1);
    bus_idle();
    hwdata_i = 32'hFF;
    #2;
    hresetn = 1'b0;
    #1;
    chk("rst_async_gpio_o", 32'(gpio_o), 32'h0);
    step(1);
    hresetn = 1'b1;
    step(2);
    chk("rst_mid_gpio_o", 32'(gpio_o), 32'h0);
    chk("rst_mid_gpio_oe", 32'(gpio_oe_o), 32'h0);
    chk("rst_mid_irq", 32'(irq_o), 32'h0);
    do_read(32'h04, rd);
    chk("rst_mid_read_out", rd, 32'h0);
    do_read(32'h1C, rd);
    chk("rst_mid_read_itype", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
